sbox_seq_ctrl: RTL and testbench
================================

// Module: sbox_seq_ctrl
// PURPOSE
//  Sequencer that sits directly upstream of a chain of NBITS/8 bit-serial S-box byte registers.
//  The chain is one 8-bit shift-or-substitute register per byte.
//  It streams serial state bits into the chain and loops the chain output back for ROUNDS passes.
//  On each pass it pulses ctrl_sbox once per byte so every byte is substituted.
//  It then unloads the result serially to the downstream consumer.
// PARAMETERS
//  NBITS   128  state width in bits; multiple of 8, >= 8
//  ROUNDS  4    substitution passes per operation; >= 1
//  CW      $clog2(NBITS)  localparam; bit-counter width
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-high
//  start       in   1   request an operation; accepted only when ready=1
//  ser_in      in   1   serial plaintext bit; sampled only in LOAD
//  fb_in       in   1   serial output of the last register in the chain (feedback)
//  ready       out  1   1 in IDLE only
//  busy        out  1   1 in LOAD/SUB/UNLOAD/DONE
//  shift_out   out  1   serial bit into the first register of the chain
//  ctrl_sbox   out  1   to all chain registers: 1 = load S-box result, 0 = shift
//  dout        out  1   serial result bit; equals fb_in while dout_valid=1, else 0
//  dout_valid  out  1   1 during UNLOAD
//  done        out  1   one-cycle pulse at end of operation
//  round_idx   out  8   current pass number (0..ROUNDS-1) in SUB; 0 otherwise
// BEHAVIOUR
//  - State: FSM {IDLE, LOAD, SUB, UNLOAD, DONE}, bit_cnt[CW-1:0], round counter. All flops reset async by rst.
//  - Reset values:
//      - state=IDLE, bit_cnt=0, round=0.
//      - ready=1; busy, ctrl_sbox, shift_out, dout, dout_valid, done, round_idx all 0.
//  - Output decode:
//      - Outputs are decoded from registered state/bit_cnt.
//      - The only combinational input->output paths are shift_out (ser_in/fb_in mux) and dout (fb_in).
//  - IDLE:
//      - start=1 -> LOAD next edge, bit_cnt=0. start=0 -> stay.
//      - shift_out=0.
//  - LOAD (NBITS cycles):
//      - shift_out=ser_in, ctrl_sbox=0.
//      - bit_cnt increments each cycle.
//      - At bit_cnt=NBITS-1 -> SUB, bit_cnt=0, round=0.
//  - SUB (NBITS cycles per round):
//      - shift_out=fb_in.
//      - ctrl_sbox = (bit_cnt[2:0]==3'd7), i.e. on the cycle the 8th bit of each byte is presented.
//        This gives exactly NBITS/8 pulses per round, first at bit_cnt=7, last at bit_cnt=NBITS-1.
//      - At bit_cnt=NBITS-1: bit_cnt wraps to 0. If round==ROUNDS-1 -> UNLOAD, else round++.
//  - UNLOAD (NBITS cycles):
//      - shift_out=0 (flush), ctrl_sbox=0.
//      - dout_valid=1, dout=fb_in.
//      - At bit_cnt=NBITS-1 -> DONE.
//  - DONE (1 cycle):
//      - done=1 -> IDLE.
//  - Latency: if start is sampled at edge T, done is high in cycle T+1+(ROUNDS+2)*NBITS.
//  - Boundaries:
//      - start while busy: ignored, no queuing.
//      - start held high through DONE: re-accepted on the first IDLE cycle.
//      - ctrl_sbox is never 1 outside SUB.
//      - NBITS=8: one ctrl_sbox per round.
//      - ROUNDS=1: SUB lasts exactly NBITS cycles.
//      - rst mid-operation: immediate return to reset values. Chain contents are don't-care; the next start performs a full LOAD.
//  - Counter widths:
//      - bit_cnt compares against NBITS-1 explicitly; never relies on natural wrap.
//      - The round counter saturates at ROUNDS-1 by construction.
// TESTING
//  1. Reset: assert rst mid-SUB (NBITS=16, ROUNDS=2) -> next cycle ready=1, busy=0, ctrl_sbox=0, round_idx=0.
//  2. Timing, NBITS=16, ROUNDS=2: start at T -> LOAD T+1..T+16, SUB T+17..T+48, UNLOAD T+49..T+64, done=1 only at T+65.
//  3. ctrl_sbox count: NBITS=128, ROUNDS=4 -> exactly 64 pulses, all in SUB, each at bit_cnt[2:0]=7; none in LOAD/UNLOAD.
//  4. Data path: chain model with identity S-box, ser_in=16'hA5C3 MSB-first -> dout stream equals 16'hA5C3.
//     With AES S-box and ROUNDS=1, byte 8'h00 unloads as 8'h63.
//  5. start ignored: pulse start during LOAD and SUB -> no restart; only one done.
//     start held high -> second op begins the cycle after IDLE is re-entered.
//  6. Edge params: NBITS=8, ROUNDS=1, start -> single ctrl_sbox at LOAD-end+8; done at T+25.

Source files
------------

// File: rtl/sbox_seq_ctrl_if.sv
// Serial handshake/data bundle between the S-box sequencer and its neighbours.
// slave = sequencer side; master = requester, chain and consumer side.
interface sbox_seq_ctrl_if;
    logic       start;
    logic       ser_in;
    logic       fb_in;
    logic       ready;
    logic       busy;
    logic       shift_out;
    logic       ctrl_sbox;
    logic       dout;
    logic       dout_valid;
    logic       done;
    logic [7:0] round_idx;

    modport slave (
        input  start, ser_in, fb_in,
        output ready, busy, shift_out, ctrl_sbox, dout, dout_valid, done, round_idx
    );

    modport master (
        output start, ser_in, fb_in,
        input  ready, busy, shift_out, ctrl_sbox, dout, dout_valid, done, round_idx
    );
endinterface

// File: rtl/sbox_seq_ctrl.sv
// Streams a state into a bit-serial S-box chain, recirculates it for ROUNDS substitution passes, then unloads it.
// Latency: start accepted at edge T -> done in cycle T+1+(ROUNDS+2)*NBITS; start is ignored while busy.
module sbox_seq_ctrl #(
    parameter int NBITS  = 128,
    parameter int ROUNDS = 4
) (
    input  logic           clk,
    input  logic           rst,
    sbox_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(NBITS);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(NBITS - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SUB,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]   round_q, round_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            round_q   <= round_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        round_d        = round_q;
        bus.ready      = 1'b0;
        bus.busy       = 1'b0;
        bus.shift_out  = 1'b0;
        bus.ctrl_sbox  = 1'b0;
        bus.dout       = 1'b0;
        bus.dout_valid = 1'b0;
        bus.done       = 1'b0;
        bus.round_idx  = 8'd0;

        case (state_q)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                end
            end

            S_LOAD: begin
                bus.busy      = 1'b1;
                bus.shift_out = bus.ser_in;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_SUB;
                    bit_cnt_d = '0;
                    round_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            S_SUB: begin
                bus.busy      = 1'b1;
                bus.shift_out = bus.fb_in;
                // Substitute as the 8th bit of each byte enters its register.
                bus.ctrl_sbox = (bit_cnt_q[2:0] == 3'd7);
                bus.round_idx = 8'(round_q);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_UNLOAD;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            S_UNLOAD: begin
                bus.busy       = 1'b1;
                bus.dout_valid = 1'b1;
                bus.dout       = bus.fb_in;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Bench for sbox_seq_ctrl: three instances (16x2 identity chain, 128x4 pulse counting, 8x1 AES chain).
module tb_sbox_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int   n_chk  = 0;
    int   n_fail = 0;

    sbox_seq_ctrl_if ifa ();
    sbox_seq_ctrl_if ifb ();
    sbox_seq_ctrl_if ifc ();

    sbox_seq_ctrl #(.NBITS(16),  .ROUNDS(2)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    sbox_seq_ctrl #(.NBITS(128), .ROUNDS(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
    sbox_seq_ctrl #(.NBITS(8),   .ROUNDS(1)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'd0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'd0;
        for (int i = 1; i < 256; i++)
            if (gmul(v, 8'(i)) == 8'd1) inv = 8'(i);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Chain models: A is two identity byte registers, C is one AES byte register.
    logic [15:0] chain_a = 16'd0;
    logic [7:0]  chain_c = 8'd0;
    always @(posedge clk) chain_a <= {chain_a[14:0], ifa.shift_out};
    always @(posedge clk) begin
        if (ifc.ctrl_sbox) chain_c <= aes_sbox({chain_c[6:0], ifc.shift_out});
        else               chain_c <= {chain_c[6:0], ifc.shift_out};
    end
    assign ifa.fb_in = chain_a[15];
    assign ifb.fb_in = 1'b0;
    assign ifc.fb_in = chain_c[7];

    logic q_a[$];
    logic q_c[$];

    always @(negedge clk) begin
        if (ifa.dout_valid) begin
            chk("a_q_nonempty", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) chk("a_dout", 32'(ifa.dout), 32'(q_a.pop_front()));
        end else begin
            chk("a_dout_gated", 32'(ifa.dout), 32'd0);
        end
        if (ifc.dout_valid) begin
            chk("c_q_nonempty", 32'(q_c.size() > 0), 32'd1);
            if (q_c.size() > 0) chk("c_dout", 32'(ifc.dout), 32'(q_c.pop_front()));
        end
    end

    // {ready, busy, ctrl_sbox, dout_valid, done, round_idx}
    function automatic logic [12:0] obs(input int sel);
        case (sel)
            0:       return {ifa.ready, ifa.busy, ifa.ctrl_sbox, ifa.dout_valid, ifa.done, ifa.round_idx};
            1:       return {ifb.ready, ifb.busy, ifb.ctrl_sbox, ifb.dout_valid, ifb.done, ifb.round_idx};
            default: return {ifc.ready, ifc.busy, ifc.ctrl_sbox, ifc.dout_valid, ifc.done, ifc.round_idx};
        endcase
    endfunction

    // Expected outputs in cycle c of an operation (cycle 1 = first LOAD cycle).
    function automatic logic [12:0] exp_vec(input int nb, input int rounds, input int c);
        int k;
        if (c >= 1 && c <= nb) return 13'b0_1000_0000_0000;
        if (c > nb && c <= nb * (rounds + 1)) begin
            k = c - nb - 1;
            return {2'b01, ((k % 8) == 7), 2'b00, 8'(k / nb)};
        end
        if (c > nb * (rounds + 1) && c <= nb * (rounds + 2)) return 13'b0_1010_0000_0000;
        if (c == nb * (rounds + 2) + 1) return 13'b0_1001_0000_0000;
        return 13'b1_0000_0000_0000;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    task automatic set_ser(input int sel, input logic v);
        case (sel)
            0:       ifa.ser_in = v;
            1:       ifb.ser_in = v;
            default: ifc.ser_in = v;
        endcase
    endtask

    task automatic run_op(input int sel, input int nb, input int rounds, input string tag,
                          input logic [127:0] data, input logic [127:0] expd,
                          input int p1, input int p2, input bit hold);
        int last;
        int n_ctrl;
        logic [12:0] o;
        last   = nb * (rounds + 2) + 1;
        n_ctrl = 0;
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(obs(sel)), 32'(exp_vec(nb, rounds, 0)));
        set_start(sel, 1'b1);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            o = obs(sel);
            chk($sformatf("%s_cyc%0d", tag, c), 32'(o), 32'(exp_vec(nb, rounds, c)));
            if (o[10]) n_ctrl++;
            set_start(sel, hold || c == p1 || c == p2);
            if (c <= nb) begin
                set_ser(sel, data[nb - c]);
                if (sel == 0) q_a.push_back(expd[nb - c]);
                if (sel == 2) q_c.push_back(expd[nb - c]);
            end
        end
        chk({tag, "_ctrl_count"}, 32'(n_ctrl), 32'(rounds * nb / 8));
    endtask

    initial begin
        logic [15:0] r;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        ifa.ser_in = 1'b0; ifb.ser_in = 1'b0; ifc.ser_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_reset", 32'(obs(0)), 32'h1000);
        chk("b_reset", 32'(obs(1)), 32'h1000);
        chk("c_reset", 32'(obs(2)), 32'h1000);
        chk("a_reset_shift", 32'(ifa.shift_out), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        run_op(0, 16, 2, "a_a5c3", 128'hA5C3, 128'hA5C3, 0, 0, 1'b0);
        r = 16'($urandom);
        run_op(0, 16, 2, "a_ign", 128'(r), 128'(r), 5, 20, 1'b0);
        r = 16'($urandom);
        run_op(0, 16, 2, "a_hold", 128'(r), 128'(r), 0, 0, 1'b1);

        // Second op was accepted in the first IDLE cycle; reset it mid-SUB.
        @(negedge clk);
        chk("a_hold_restart", 32'(obs(0)), 32'(exp_vec(16, 2, 1)));
        ifa.start = 1'b0;
        repeat (24) @(negedge clk);
        chk("a_pre_rst", 32'(obs(0)), 32'(exp_vec(16, 2, 25)));
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_rst_mid", 32'(obs(0)), 32'h1000);
        rst_a = 1'b0;
        q_a.delete();

        run_op(0, 16, 2, "a_post_rst", 128'h3C5A, 128'h3C5A, 0, 0, 1'b0);
        run_op(1, 128, 4, "b", 128'd0, 128'd0, 0, 0, 1'b0);
        run_op(2, 8, 1, "c_00", 128'h00, 128'h63, 0, 0, 1'b0);
        run_op(2, 8, 1, "c_53", 128'h53, 128'hED, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("a_q_drained", 32'(q_a.size()), 32'd0);
        chk("c_q_drained", 32'(q_c.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
